// File: rtl/mem_pkg.sv
// Definitions shared between main_memory and the data cache: line geometry
// defaults and the memory-side FSM state encoding.
package mem_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE  = 32;
  localparam int unsigned DEFAULT_BLOCK_SIZE = 4;
  localparam int unsigned LINE_BITS          = 128;
  localparam int unsigned LINE_OFFSET_BITS   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Line storage for main_memory: synchronous write, registered read that holds
// its value until the next read strobe. Contents are not reset.
module mem_array #(
  parameter int unsigned DEPTH_BLOCKS = 256,
  parameter int unsigned LINE_W       = 128,
  localparam int unsigned IDX_W       = $clog2(DEPTH_BLOCKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH_BLOCKS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[idx];
  end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency line memory behind the data cache (ready/valid, one line per
// request). Define MEM_RANGE_CHECK_EN to flag accesses above DEPTH_BLOCKS lines.
module main_memory
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int unsigned BLOCK_SIZE   = DEFAULT_BLOCK_SIZE,
  parameter int unsigned DEPTH_BLOCKS = 256,
  parameter int unsigned LATENCY      = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            read_mem,
  input  logic                            write_mem,
  input  logic [31:0]                     addr_mem,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] wdata_mem,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] rdata_mem,
  output logic                            ready_mem,
  output logic                            valid_mem,
  output logic                            err_mem
);

  localparam int unsigned LINE_W = WORD_SIZE * BLOCK_SIZE;
  localparam int unsigned IDX_W  = $clog2(DEPTH_BLOCKS);
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  mem_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [IDX_W-1:0]  idx_q, idx_nx;
  logic              op_wr_q, op_wr_nx;
  logic [LINE_W-1:0] wdata_q, wdata_nx;
  logic              flag_q, flag_nx;
  logic              ready_nx, valid_nx, err_nx;
  logic              commit;
  logic              addr_oor;
  logic              unused_addr;

  // Offset bits, and the upper bits in the aliasing build, are don't-care.
  assign unused_addr = ^addr_mem;

`ifdef MEM_RANGE_CHECK_EN
  assign addr_oor = (addr_mem >> (LINE_OFFSET_BITS + IDX_W)) != '0;
`else
  assign addr_oor = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      op_wr_q   <= 1'b0;
      wdata_q   <= '0;
      flag_q    <= 1'b0;
      ready_mem <= 1'b1;
      valid_mem <= 1'b0;
      err_mem   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx_q     <= idx_nx;
      op_wr_q   <= op_wr_nx;
      wdata_q   <= wdata_nx;
      flag_q    <= flag_nx;
      ready_mem <= ready_nx;
      valid_mem <= valid_nx;
      err_mem   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx_q;
    op_wr_nx = op_wr_q;
    wdata_nx = wdata_q;
    flag_nx  = flag_q;
    ready_nx = ready_mem;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        // A write wins when both requests are raised together.
        if (ready_mem && (read_mem || write_mem)) begin
          state_nx = BUSY;
          cnt_nx   = CNT_W'(LATENCY - 1);
          idx_nx   = addr_mem[LINE_OFFSET_BITS +: IDX_W];
          op_wr_nx = write_mem;
          wdata_nx = wdata_mem;
          flag_nx  = addr_oor;
          ready_nx = 1'b0;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nx = DONE;
          commit   = 1'b1;
          valid_nx = 1'b1;
          err_nx   = flag_q;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  mem_array #(
    .DEPTH_BLOCKS(DEPTH_BLOCKS),
    .LINE_W      (LINE_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (commit && op_wr_q && !flag_q),
    .re   (commit && !op_wr_q && !flag_q),
    .clr  (commit && !op_wr_q && flag_q),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(rdata_mem)
  );

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed scenarios plus randomized
// accesses against a line-level reference model.
module tb_main_memory;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         read_mem, write_mem;
  logic [31:0]  addr_mem;
  logic [127:0] wdata_mem, rdata_mem;
  logic         ready_mem, valid_mem, err_mem;

  logic         f_read, f_write;
  logic [31:0]  f_addr;
  logic [127:0] f_wdata, f_rdata;
  logic         f_ready, f_valid, f_err;

  main_memory #(.WORD_SIZE(32), .BLOCK_SIZE(4), .DEPTH_BLOCKS(256), .LATENCY(5)) dut (
    .clk(clk), .reset(reset), .read_mem(read_mem), .write_mem(write_mem),
    .addr_mem(addr_mem), .wdata_mem(wdata_mem), .rdata_mem(rdata_mem),
    .ready_mem(ready_mem), .valid_mem(valid_mem), .err_mem(err_mem));

  main_memory #(.WORD_SIZE(32), .BLOCK_SIZE(4), .DEPTH_BLOCKS(256), .LATENCY(1)) dut_fast (
    .clk(clk), .reset(reset), .read_mem(f_read), .write_mem(f_write),
    .addr_mem(f_addr), .wdata_mem(f_wdata), .rdata_mem(f_rdata),
    .ready_mem(f_ready), .valid_mem(f_valid), .err_mem(f_err));

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] PLAN_DATA = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  // Reference model: line contents and the last value presented on rdata_mem.
  logic [127:0] model_mem [256];
  bit           model_known [256];
  logic [127:0] model_rdata;
  bit           model_rknown;

  int           o_ready_low, o_valid_edge, o_valid_cnt;
  logic [127:0] o_rdata;
  logic         o_err, o_timeout;

  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [127:0] d, output logic [127:0] er,
                             output logic eerr, output bit ek);
    int unsigned line;
    bit oor;
    line = int'(a[11:4]);
`ifdef MEM_RANGE_CHECK_EN
    oor = (a[31:12] != 20'd0);
`else
    oor = 1'b0;
`endif
    eerr = oor;
    if (oor) begin
      if (!wr) begin model_rdata = '0; model_rknown = 1'b1; end
    end else if (wr) begin
      model_mem[line] = d;
      model_known[line] = 1'b1;
    end else if (rd) begin
      model_rdata = model_mem[line];
      model_rknown = model_known[line];
    end
    er = model_rdata;
    ek = model_rknown;
  endtask

  // Drives one request into dut and records what the handshake did.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [127:0] d);
    int n;
    bit done;
    o_timeout = 1'b0; o_ready_low = 0; o_valid_edge = -1; o_valid_cnt = 0;
    o_rdata = 'x; o_err = 1'bx; done = 1'b0; n = 0;
    @(negedge clk);
    while (!ready_mem && n < 50) begin @(negedge clk); n++; end
    if (!ready_mem) begin o_timeout = 1'b1; return; end
    read_mem = rd; write_mem = wr; addr_mem = a; wdata_mem = d;
    @(posedge clk);
    #1;
    read_mem = 1'b0; write_mem = 1'b0;
    addr_mem = $urandom; wdata_mem = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_mem) begin
        o_valid_cnt++;
        if (o_valid_edge < 0) begin
          o_valid_edge = k - 1; o_rdata = rdata_mem; o_err = err_mem;
        end
      end
      if (!ready_mem) o_ready_low++;
      else begin done = 1'b1; break; end
    end
    if (!done) o_timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    read_mem = 0; write_mem = 0; addr_mem = '0; wdata_mem = '0;
    f_read = 0; f_write = 0; f_addr = '0; f_wdata = '0;
    #12;
    checks++; if (ready_mem !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_mem); end
    checks++; if (valid_mem !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_mem); end
    checks++; if (rdata_mem !== 128'd0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata_mem); end
    checks++; if (err_mem !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_mem); end
    checks++; if (f_ready !== 1'b1) begin failures++; $display("FAIL reset_fast_ready: got %b expected 1", f_ready); end
    @(negedge clk); reset = 1'b0;
    model_rdata = '0; model_rknown = 1'b1;
  endtask

  task automatic test_write_read();
    logic [127:0] er; logic eerr; bit ek;
    access(1'b0, 1'b1, 32'h40, PLAN_DATA);
    model_apply(1'b0, 1'b1, 32'h40, PLAN_DATA, er, eerr, ek);
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL wr40_timeout: got %b expected 0", o_timeout); end
    checks++; if (o_ready_low != 6) begin failures++; $display("FAIL wr40_ready_low: got %0d expected 6", o_ready_low); end
    checks++; if (o_valid_edge != 5) begin failures++; $display("FAIL wr40_valid_edge: got %0d expected 5", o_valid_edge); end
    checks++; if (o_valid_cnt != 1) begin failures++; $display("FAIL wr40_valid_cnt: got %0d expected 1", o_valid_cnt); end
    checks++; if (o_rdata !== 128'd0) begin failures++; $display("FAIL wr40_rdata_held: got %h expected 0", o_rdata); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL wr40_err: got %b expected 0", o_err); end
    access(1'b1, 1'b0, 32'h4C, '0);
    model_apply(1'b1, 1'b0, 32'h4C, '0, er, eerr, ek);
    checks++; if (o_valid_edge != 5) begin failures++; $display("FAIL rd4c_valid_edge: got %0d expected 5", o_valid_edge); end
    checks++; if (o_rdata !== PLAN_DATA) begin failures++; $display("FAIL rd4c_rdata: got %h expected %h", o_rdata, PLAN_DATA); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rd4c_err: got %b expected 0", o_err); end
  endtask

  task automatic test_both_requests();
    logic [127:0] er; logic eerr; bit ek;
    access(1'b1, 1'b1, 32'h80, '1);
    model_apply(1'b1, 1'b1, 32'h80, '1, er, eerr, ek);
    checks++; if (o_valid_cnt != 1) begin failures++; $display("FAIL both_valid_cnt: got %0d expected 1", o_valid_cnt); end
    checks++; if (o_rdata !== PLAN_DATA) begin failures++; $display("FAIL both_rdata_held: got %h expected %h", o_rdata, PLAN_DATA); end
    access(1'b1, 1'b0, 32'h80, '0);
    model_apply(1'b1, 1'b0, 32'h80, '0, er, eerr, ek);
    checks++; if (o_rdata !== {128{1'b1}}) begin failures++; $display("FAIL both_line8: got %h expected all-ones", o_rdata); end
  endtask

  task automatic test_reset_mid_access();
    logic [127:0] er; logic eerr; bit ek;
    logic [127:0] old_line, new_line;
    bit seen;
    old_line = {$urandom, $urandom, $urandom, $urandom};
    new_line = ~old_line;
    access(1'b0, 1'b1, 32'h100, old_line);
    model_apply(1'b0, 1'b1, 32'h100, old_line, er, eerr, ek);
    @(negedge clk);
    write_mem = 1'b1; addr_mem = 32'h100; wdata_mem = new_line;
    @(posedge clk);
    #1 write_mem = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (ready_mem !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", ready_mem); end
    checks++; if (valid_mem !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", valid_mem); end
    checks++; if (rdata_mem !== 128'd0) begin failures++; $display("FAIL midrst_rdata: got %h expected 0", rdata_mem); end
    @(negedge clk); reset = 1'b0;
    model_rdata = '0; model_rknown = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (valid_mem) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_valid: got %b expected 0", seen); end
    access(1'b1, 1'b0, 32'h100, '0);
    model_apply(1'b1, 1'b0, 32'h100, '0, er, eerr, ek);
    checks++; if (o_rdata !== old_line) begin failures++; $display("FAIL midrst_line: got %h expected %h", o_rdata, old_line); end
  endtask

  task automatic test_range();
    logic [127:0] er; logic eerr; bit ek;
    logic [127:0] l0, l1, wbad, exp_rd, exp_l1;
    logic exp_err;
    l0 = {$urandom, $urandom, $urandom, $urandom};
    l1 = {$urandom, $urandom, $urandom, $urandom};
    wbad = ~l1;
    access(1'b0, 1'b1, 32'h0, l0);   model_apply(1'b0, 1'b1, 32'h0, l0, er, eerr, ek);
    access(1'b0, 1'b1, 32'h10, l1);  model_apply(1'b0, 1'b1, 32'h10, l1, er, eerr, ek);
`ifdef MEM_RANGE_CHECK_EN
    exp_rd = '0; exp_err = 1'b1; exp_l1 = l1;
`else
    exp_rd = l0; exp_err = 1'b0; exp_l1 = wbad;
`endif
    access(1'b1, 1'b0, 32'h0000_1000, '0);
    model_apply(1'b1, 1'b0, 32'h0000_1000, '0, er, eerr, ek);
    checks++; if (o_valid_edge != 5) begin failures++; $display("FAIL range_valid_edge: got %0d expected 5", o_valid_edge); end
    checks++; if (o_err !== exp_err) begin failures++; $display("FAIL range_err: got %b expected %b", o_err, exp_err); end
    checks++; if (o_rdata !== exp_rd) begin failures++; $display("FAIL range_rdata: got %h expected %h", o_rdata, exp_rd); end
    access(1'b0, 1'b1, 32'h0000_1010, wbad);
    model_apply(1'b0, 1'b1, 32'h0000_1010, wbad, er, eerr, ek);
    checks++; if (o_err !== exp_err) begin failures++; $display("FAIL range_wr_err: got %b expected %b", o_err, exp_err); end
    access(1'b1, 1'b0, 32'h10, '0);
    model_apply(1'b1, 1'b0, 32'h10, '0, er, eerr, ek);
    checks++; if (o_rdata !== exp_l1) begin failures++; $display("FAIL range_line1: got %h expected %h", o_rdata, exp_l1); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL range_inrange_err: got %b expected 0", o_err); end
  endtask

  task automatic test_random();
    logic [127:0] er, d; logic eerr; bit ek;
    logic rd, wr;
    logic [31:0] a, upper;
    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      upper = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 32'hF_FFFF)) : 32'd0;
      a = (upper << 12) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      access(rd, wr, a, d);
      model_apply(rd, wr, a, d, er, eerr, ek);
      checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout: got %b expected 0", i, o_timeout); end
      checks++; if (o_valid_edge != 5) begin failures++; $display("FAIL rand%0d_valid_edge: got %0d expected 5", i, o_valid_edge); end
      checks++; if (o_ready_low != 6) begin failures++; $display("FAIL rand%0d_ready_low: got %0d expected 6", i, o_ready_low); end
      checks++; if (o_valid_cnt != 1) begin failures++; $display("FAIL rand%0d_valid_cnt: got %0d expected 1", i, o_valid_cnt); end
      checks++; if (o_err !== eerr) begin failures++; $display("FAIL rand%0d_err: got %b expected %b", i, o_err, eerr); end
      if (ek) begin
        checks++; if (o_rdata !== er) begin failures++; $display("FAIL rand%0d_rdata: got %h expected %h", i, o_rdata, er); end
      end
    end
  endtask

  int           acc_cyc [2];
  int           val_cyc [2];
  logic [127:0] val_rdata [2];
  int           n_acc, n_val;

  // Holds a request on dut_fast continuously, retargeting it once accepted.
  task automatic hold_pair(input logic rd, input logic wr, input logic [31:0] a0,
                           input logic [127:0] d0, input logic [31:0] a1, input logic [127:0] d1);
    int cyc;
    bit acc_now;
    n_acc = 0; n_val = 0; cyc = 0;
    acc_cyc[0] = -100; acc_cyc[1] = 100; val_cyc[0] = -100; val_cyc[1] = 100;
    val_rdata[0] = 'x; val_rdata[1] = 'x;
    @(negedge clk);
    f_read = rd; f_write = wr; f_addr = a0; f_wdata = d0;
    for (int n = 0; n < 40; n++) begin
      acc_now = f_ready && (f_read || f_write);
      @(posedge clk); cyc++;
      if (acc_now && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
      @(negedge clk);
      if (f_valid && n_val < 2) begin val_rdata[n_val] = f_rdata; val_cyc[n_val] = cyc; n_val++; end
      if (n_acc == 1) begin f_addr = a1; f_wdata = d1; end
      if (n_acc == 2) begin f_read = 1'b0; f_write = 1'b0; end
      if (n_acc == 2 && n_val == 2) break;
    end
    f_read = 1'b0; f_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] la, lb;
    la = {$urandom, $urandom, $urandom, $urandom};
    lb = {$urandom, $urandom, $urandom, $urandom};
    hold_pair(1'b0, 1'b1, 32'h00, la, 32'h10, lb);
    checks++; if (n_val != 2) begin failures++; $display("FAIL b2b_wr_valids: got %0d expected 2", n_val); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 3) begin failures++; $display("FAIL b2b_wr_spacing: got %0d expected 3", acc_cyc[1] - acc_cyc[0]); end
    hold_pair(1'b1, 1'b0, 32'h00, '0, 32'h10, '0);
    checks++; if (acc_cyc[1] - acc_cyc[0] != 3) begin failures++; $display("FAIL b2b_rd_spacing: got %0d expected 3", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (val_cyc[0] - acc_cyc[0] != 1) begin failures++; $display("FAIL b2b_rd_latency: got %0d expected 1", val_cyc[0] - acc_cyc[0]); end
    checks++; if (val_rdata[0] !== la) begin failures++; $display("FAIL b2b_rd0: got %h expected %h", val_rdata[0], la); end
    checks++; if (val_rdata[1] !== lb) begin failures++; $display("FAIL b2b_rd1: got %h expected %h", val_rdata[1], lb); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
    test_reset();
    test_write_read();
    test_both_requests();
    test_reset_mid_access();
    test_range();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
